// File: rtl/ifid_hazard_ctrl.sv
// Front-end hazard sequencer for the 8-bit core. It decides each cycle whether the PC and IF/ID
// advance, hold or flush, and it counts the cycles in which the PC was held.
module ifid_hazard_ctrl #(
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_rs1,
  input  logic [2:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [2:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {StRun, StLuStall, StFlush, StImemWait} state_e;

  localparam logic [3:0] LuInit    = 4'(LOAD_STALL - 1);
  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic hazard;
  logic pc_w, ifid_w, flush_w, bubble_w;

  assign hazard = ex_memread & ((id_use_rs1 & (id_rs1 == ex_rd)) |
                                (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    flush_w  = 1'b0;
    bubble_w = 1'b0;

    if (branch_taken) begin
      // A taken branch aborts any state in progress and restarts the flush window.
      flush_w  = 1'b1;
      bubble_w = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        cnt_d   = FlushInit;
      end else begin
        state_d = StRun;
        cnt_d   = 4'd0;
      end
    end else begin
      unique case (state_q)
        StLuStall: begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          bubble_w = 1'b1;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StRun;
        end
        StFlush: begin
          // Only fetch cycles that return data count as a flushed slot.
          pc_w     = imem_ready;
          ifid_w   = imem_ready;
          flush_w  = 1'b1;
          bubble_w = 1'b1;
          if (imem_ready) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StRun;
          end
        end
        StRun, StImemWait: begin
          if (hazard) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            bubble_w = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = StLuStall;
              cnt_d   = LuInit;
            end else begin
              state_d = StRun;
            end
          end else if (!imem_ready) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            bubble_w = 1'b1;
            state_d  = StImemWait;
          end else begin
            state_d = StRun;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_w && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces a safe front end (held and flushed) without waiting for a clock edge.
  assign pc_write    = reset ? 1'b0 : pc_w;
  assign ifid_write  = reset ? 1'b0 : ifid_w;
  assign ifid_flush  = reset ? 1'b1 : flush_w;
  assign idex_bubble = reset ? 1'b1 : bubble_w;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed self-checking bench for ifid_hazard_ctrl with LOAD_STALL=3, FLUSH_CYCLES=2, CNT_W=4.
module tb_ifid_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, branch_taken, imem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [3:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  ifid_hazard_ctrl #(
    .LOAD_STALL  (3),
    .FLUSH_CYCLES(2),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .branch_taken(branch_taken),
    .imem_ready  (imem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam int Run   = 4'b1100;
  localparam int Stall = 4'b0001;
  localparam int Rst   = 4'b0011;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int outs();
    return int'({pc_write, ifid_write, ifid_flush, idex_bubble});
  endfunction

  // Branch-related checks ignore ifid_write since ifid_flush overrides it.
  function automatic int br_outs();
    return int'({pc_write, ifid_flush, idex_bubble});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_hazard_rs2();
    ex_memread = 1'b1; ex_rd = 3'd5; id_rs2 = 3'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2;
    check_eq("reset_outs", outs(), Rst);
    check_eq("reset_cnt", int'(stall_count), 0);
    tick();
    reset = 1'b0;
    #1;

    // Free-running fetch
    for (int i = 0; i < 5; i++) begin
      check_eq("run_outs", outs(), Run);
      tick();
    end
    check_eq("run_cnt", int'(stall_count), 0);

    // Matching register but not read: no hazard
    ex_memread = 1'b1; ex_rd = 3'd5; id_rs2 = 3'd5; id_use_rs2 = 1'b0;
    #1 check_eq("nohaz_unused", outs(), Run);
    // Load in EX without register match: no hazard
    id_use_rs2 = 1'b1; id_rs2 = 3'd4;
    #1 check_eq("nohaz_mismatch", outs(), Run);
    // rs1 path triggers immediately
    id_use_rs2 = 1'b0; id_use_rs1 = 1'b1; id_rs1 = 3'd5;
    #1 check_eq("haz_rs1", outs(), Stall);

    // Load-use on rs2 holds for exactly 3 cycles; hazard dropped after cycle 1
    do_reset();
    set_hazard_rs2();
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("lu_stall", outs(), Stall);
      tick();
      ex_memread = 1'b0;
    end
    #1 check_eq("lu_resume", outs(), Run);
    check_eq("lu_cnt", int'(stall_count), 3);

    // Taken branch: 2 flushed slots, PC advancing in both
    do_reset();
    branch_taken = 1'b1;
    #1 check_eq("br_c0", br_outs(), 3'b111);
    tick();
    branch_taken = 1'b0;
    #1 check_eq("br_c1", br_outs(), 3'b111);
    tick();
    #1 check_eq("br_done", outs(), Run);
    check_eq("br_cnt", int'(stall_count), 0);

    // Fetch wait inside the flush window stretches it
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    imem_ready = 1'b0;
    #1 check_eq("brw_wait", br_outs(), 3'b011);
    tick();
    imem_ready = 1'b1;
    #1 check_eq("brw_slot", br_outs(), 3'b111);
    tick();
    #1 check_eq("brw_done", outs(), Run);
    check_eq("brw_cnt", int'(stall_count), 1);

    // Branch in 2nd cycle of a load-use stall abandons the stall
    do_reset();
    set_hazard_rs2();
    #1 check_eq("ab_c0", outs(), Stall);
    tick();
    branch_taken = 1'b1;
    #1 check_eq("ab_br", br_outs(), 3'b111);
    tick();
    branch_taken = 1'b0;
    ex_memread = 1'b0;
    #1 check_eq("ab_flush", br_outs(), 3'b111);
    tick();
    #1 check_eq("ab_run", outs(), Run);
    check_eq("ab_cnt", int'(stall_count), 1);

    // Instruction memory wait for 4 cycles
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("iw_stall", outs(), Stall);
      tick();
    end
    imem_ready = 1'b1;
    #1 check_eq("iw_resume", outs(), Run);
    check_eq("iw_cnt", int'(stall_count), 4);
    tick();
    #1 check_eq("iw_run", outs(), Run);

    // Counter saturation after 20 stall cycles
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_cnt", int'(stall_count), 15);

    // Asynchronous reset in the middle of a load-use stall
    imem_ready = 1'b1;
    set_hazard_rs2();
    tick();
    #2;
    reset = 1'b1;
    #1 check_eq("mid_rst_outs", outs(), Rst);
    check_eq("mid_rst_cnt", int'(stall_count), 0);
    tick();
    idle_inputs();
    reset = 1'b0;
    #1 check_eq("post_rst_run", outs(), Run);
    tick();
    check_eq("post_rst_cnt", int'(stall_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
